// File: rtl/pwm_fade.sv
`timescale 1ns / 1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | pwm_fade : ramps a PWM compare value toward a commanded target in steps.  |
// | Option macro PWM_FADE_PERIOD_SYNC_EN: stage steps in a shadow register.   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module pwm_fade #(
    parameter int PWM_BITS   = 8,
    parameter int RATE_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [PWM_BITS-1:0]   cmd_target,
    input  logic [PWM_BITS-1:0]   cmd_step,
    input  logic [RATE_WIDTH-1:0] rate,
    input  logic                  abort,
`ifdef PWM_FADE_PERIOD_SYNC_EN
    input  logic                  period_start,
`endif
    output logic [PWM_BITS-1:0]   compare,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } state_t;

    state_t                  state_q,   state_d;
    logic [PWM_BITS-1:0]     compare_q, compare_d;
    logic [PWM_BITS-1:0]     target_q,  target_d;
    logic [PWM_BITS-1:0]     step_q,    step_d;
    logic [RATE_WIDTH-1:0]   presc_q,   presc_d;
    logic                    done_q,    done_d;
`ifdef PWM_FADE_PERIOD_SYNC_EN
    logic [PWM_BITS-1:0]     shadow_q,  shadow_d;
`endif

    logic [PWM_BITS-1:0]     step_src;
    logic [PWM_BITS-1:0]     step_next;
    logic [PWM_BITS:0]       sum_ext;
    logic [PWM_BITS:0]       dif_ext;

`ifdef PWM_FADE_PERIOD_SYNC_EN
    assign step_src = shadow_q;
`else
    assign step_src = compare_q;
`endif

    // One extra bit catches both overflow past the top and borrow below zero.
    always_comb begin
        sum_ext   = {1'b0, step_src} + {1'b0, step_q};
        dif_ext   = {1'b0, step_src} - {1'b0, step_q};
        step_next = target_q;
        if (target_q > step_src) begin
            if (sum_ext < {1'b0, target_q})
                step_next = sum_ext[PWM_BITS-1:0];
        end else begin
            if (!dif_ext[PWM_BITS] && (dif_ext > {1'b0, target_q}))
                step_next = dif_ext[PWM_BITS-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        compare_d = compare_q;
        target_d  = target_q;
        step_d    = step_q;
        presc_d   = presc_q;
        done_d    = 1'b0;
`ifdef PWM_FADE_PERIOD_SYNC_EN
        shadow_d  = shadow_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    target_d = cmd_target;
                    step_d   = (cmd_step == '0) ? PWM_BITS'(1) : cmd_step;
                    presc_d  = '0;
`ifdef PWM_FADE_PERIOD_SYNC_EN
                    shadow_d = compare_q;
`endif
                    if (cmd_target != compare_q)
                        state_d = ST_RAMP;
                    else
                        done_d  = 1'b1;
                end
            end
            ST_RAMP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    if (presc_q == rate) begin
                        presc_d = '0;
`ifdef PWM_FADE_PERIOD_SYNC_EN
                        shadow_d = step_next;
`else
                        compare_d = step_next;
                        if (step_next == target_q) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
`endif
                    end else begin
                        presc_d = presc_q + RATE_WIDTH'(1);
                    end
`ifdef PWM_FADE_PERIOD_SYNC_EN
                    // Only the period wrap may expose a new duty to the PWM.
                    if (period_start) begin
                        compare_d = shadow_q;
                        if (shadow_q == target_q) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            compare_q <= '0;
            target_q  <= '0;
            step_q    <= '0;
            presc_q   <= '0;
            done_q    <= 1'b0;
`ifdef PWM_FADE_PERIOD_SYNC_EN
            shadow_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            compare_q <= compare_d;
            target_q  <= target_d;
            step_q    <= step_d;
            presc_q   <= presc_d;
            done_q    <= done_d;
`ifdef PWM_FADE_PERIOD_SYNC_EN
            shadow_q  <= shadow_d;
`endif
        end
    end

    assign compare   = compare_q;
    assign busy      = (state_q == ST_RAMP);
    assign cmd_ready = (state_q == ST_IDLE);
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_fade.sv
`timescale 1ns / 1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pwm_fade : randomized fades checked against a closed-form fade model.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_pwm_fade;

    localparam int PWM_BITS   = 8;
    localparam int RATE_WIDTH = 16;
`ifdef PWM_FADE_PERIOD_SYNC_EN
    localparam int LAG = 1;
`else
    localparam int LAG = 0;
`endif

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [PWM_BITS-1:0]   cmd_target;
    logic [PWM_BITS-1:0]   cmd_step;
    logic [RATE_WIDTH-1:0] rate;
    logic                  abort;
    logic [PWM_BITS-1:0]   compare;
    logic                  busy;
    logic                  done;
`ifdef PWM_FADE_PERIOD_SYNC_EN
    // A wrap every cycle: compare trails the shadow by exactly one edge.
    logic                  period_start = 1'b1;
`endif

    int n_total = 0;
    int n_bad   = 0;
    int m_cmp   = 0;

    pwm_fade #(.PWM_BITS(PWM_BITS), .RATE_WIDTH(RATE_WIDTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .cmd_step   (cmd_step),
        .rate       (rate),
        .abort      (abort),
`ifdef PWM_FADE_PERIOD_SYNC_EN
        .period_start (period_start),
`endif
        .compare    (compare),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Duty after k steps, saturating at the target, no wrap.
    function automatic int fade_val(int s, int t, int eff, int k);
        int v;
        if (t > s) begin
            v = s + k * eff;
            if (v > t) v = t;
        end else begin
            v = s - k * eff;
            if (v < t) v = t;
        end
        return v;
    endfunction

    function automatic int max0(int x);
        return (x < 0) ? 0 : x;
    endfunction

    // ab = 0: no abort; otherwise abort is high for the edge ab after acceptance.
    task automatic run_fade(input int tgt, input int stp, input int rt, input int ab);
        int eff, s, n, f, lag, fin, e_cmp, e_busy, e_done;
        s    = m_cmp;
        eff  = (stp == 0) ? 1 : stp;
        n    = ((tgt > s ? tgt - s : s - tgt) + eff - 1) / eff;
        f    = n * (rt + 1);
        lag  = (tgt == s) ? 0 : LAG;
        fin  = (ab > 0) ? ab : f + lag;
        rate       = RATE_WIDTH'(rt);
        cmd_target = PWM_BITS'(tgt);
        cmd_step   = PWM_BITS'(stp);
        cmd_valid  = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        e_cmp = s;
        for (int e = 0; e <= fin; e++) begin
            if (tgt == s) begin
                e_cmp = s; e_busy = 0; e_done = 1;
            end else if (ab > 0) begin
                e_cmp  = (e >= ab) ? fade_val(s, tgt, eff, max0(ab - 1 - lag) / (rt + 1))
                                   : fade_val(s, tgt, eff, max0(e - lag) / (rt + 1));
                e_busy = (e < ab) ? 1 : 0;
                e_done = 0;
            end else begin
                e_cmp  = fade_val(s, tgt, eff, max0(e - lag) / (rt + 1));
                e_busy = (e < f + lag) ? 1 : 0;
                e_done = (e == f + lag) ? 1 : 0;
            end
            check("compare",   int'(compare),   e_cmp);
            check("busy",      int'(busy),      e_busy);
            check("done",      int'(done),      e_done);
            check("cmd_ready", int'(cmd_ready), 1 - e_busy);
            if (e < fin) begin
                abort      = (e + 1 == ab);
                cmd_valid  = 1'($urandom_range(0, 1));
                cmd_target = PWM_BITS'($urandom);
                @(posedge clk); #1;
                abort = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        abort     = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("idle_compare", int'(compare), e_cmp);
        check("idle_busy",    int'(busy),    0);
        check("idle_done",    int'(done),    0);
        m_cmp = e_cmp;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int tg, st, rt, ab, nn, ff;
        reset_n    = 1'b0;
        cmd_valid  = 1'b0;
        cmd_target = '0;
        cmd_step   = '0;
        rate       = '0;
        abort      = 1'b0;
        #12;
        check("rst_compare",   int'(compare),   0);
        check("rst_busy",      int'(busy),      0);
        check("rst_done",      int'(done),      0);
        check("rst_cmd_ready", int'(cmd_ready), 1);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        run_fade(10, 3, 1, 0);
        run_fade(2, 5, 0, 0);
        run_fade(250, 250, 0, 0);
        run_fade(255, 20, 0, 0);
        run_fade(5, 250, 0, 0);
        run_fade(5, 9, 2, 0);
        run_fade(0, 255, 0, 0);
        run_fade(200, 1, 3, 164);
        run_fade(43, 0, 0, 0);

        for (int i = 0; i < 20; i++) begin
            tg = int'($urandom_range(0, 255));
            st = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255));
            rt = int'($urandom_range(0, 3));
            ab = 0;
            if (tg != m_cmp && $urandom_range(0, 3) == 0) begin
                nn = ((tg > m_cmp ? tg - m_cmp : m_cmp - tg) + (st == 0 ? 1 : st) - 1)
                     / (st == 0 ? 1 : st);
                ff = nn * (rt + 1) + LAG;
                ab = int'($urandom_range(1, ff));
            end
            run_fade(tg, st, rt, ab);
        end

        rate       = '0;
        cmd_target = 8'd200;
        cmd_step   = 8'd1;
        cmd_valid  = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("async_rst_compare", int'(compare), 0);
        check("async_rst_busy",    int'(busy),    0);
        check("async_rst_done",    int'(done),    0);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_compare", int'(compare), 0);
        check("post_rst_busy",    int'(busy),    0);
        check("post_rst_done",    int'(done),    0);
        m_cmp = 0;
        run_fade(7, 2, 1, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwm_fade.md
PWM_FADE -- requirements
Module: pwm_fade

Interface
REQ-001 Parameter PWM_BITS, default 8, width of the duty value driven to the downstream PWM compare input.
REQ-002 Parameter RATE_WIDTH, default 16, width of the step-interval prescaler.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  fade command offered.
REQ-006 cmd_ready  output  1  block can accept a command; high exactly when the state is IDLE.
REQ-007 cmd_target  input  PWM_BITS  final duty value.
REQ-008 cmd_step  input  PWM_BITS  duty increment per step; a value of 0 is treated as 1.
REQ-009 rate  input  RATE_WIDTH  number of idle cycles between steps, sampled continuously.
REQ-010 abort  input  1  stops an active fade.
REQ-011 compare  output  PWM_BITS  registered duty value, fed to the PWM compare input.
REQ-012 busy  output  1  high in the RAMP state.
REQ-013 done  output  1  one-cycle pulse when a fade reaches its target.

Function
REQ-014 The state machine SHALL have two states:
  - IDLE -> RAMP on cmd_valid & cmd_ready when cmd_target != compare.
  - RAMP -> IDLE when compare reaches the target, or on abort.
REQ-015 On acceptance the block SHALL latch cmd_target and the effective step (cmd_step, or 1 if cmd_step is 0), and SHALL clear the prescaler.
REQ-016 In RAMP the prescaler SHALL count up each cycle; when it equals rate, a step SHALL occur and the prescaler SHALL clear, so steps are spaced rate+1 cycles apart and the first step lands rate+1 cycles after acceptance.
REQ-017 A step SHALL move compare toward the target by the step value and SHALL saturate at the target.
  - Compute with PWM_BITS+1 bits internally.
  - No overshoot and no wrap in either direction.
REQ-018 The edge that writes compare equal to the target SHALL move the state to IDLE and assert done for exactly that one cycle; busy SHALL be low and cmd_ready high in that same cycle.
REQ-019 A command accepted with cmd_target equal to compare SHALL leave the state IDLE, leave compare unchanged, and pulse done on the next cycle.
REQ-020 abort in RAMP SHALL return the state to IDLE on the next edge with compare frozen and no done pulse; abort in IDLE SHALL have no effect.
REQ-021 When abort and a step coincide, abort SHALL win and compare SHALL hold its pre-step value.
REQ-022 Commands SHALL be ignored while busy; cmd_valid held high SHALL be accepted in the first cycle cmd_ready is high.
REQ-023 A change to rate mid-fade SHALL take effect at the next prescaler comparison.

Reset
REQ-024 Assertion of reset_n low SHALL immediately set the following, regardless of the clock:
  - state IDLE
  - compare = 0
  - prescaler = 0
  - latched target/step = 0
  - busy = 0, done = 0
REQ-025 Reset mid-fade SHALL abandon the fade with no done pulse; operation SHALL resume on the first clk edge after reset_n deasserts.

Configuration
REQ-026 Macro PWM_FADE_PERIOD_SYNC_EN.
  - Defined: the block adds input period_start (1 bit, pulse at each downstream PWM period wrap). Steps SHALL still be computed per REQ-016 into a shadow register, and compare SHALL load the shadow only on period_start. RAMP->IDLE and done SHALL occur on the period_start edge that loads the target value.
  - Undefined: period_start is absent, there is no shadow register, and compare updates directly per REQ-017/REQ-018.

Verification
REQ-027 From reset, cmd target=10, step=3, rate=1 -> compare 3,6,9,10 at cycles 2,4,6,8 after acceptance; done high only at cycle 8; busy low from cycle 8.
REQ-028 compare=10, cmd target=2, step=5, rate=0 -> compare 5 then 2 on consecutive cycles; done once; no wrap below 0.
REQ-029 PWM_BITS=8, compare=250, target=255, step=20 -> compare=255 in one step; done pulses.
REQ-030 compare=5, cmd target=5 -> no state change, done pulses next cycle, cmd_ready stays high.
REQ-031 Fade 0->200, step=1, rate=3, abort asserted at compare=40 on a step cycle -> compare holds 40, busy drops, no done; a new command is accepted the following cycle.
REQ-032 reset_n pulsed low between clk edges mid-fade -> compare=0 and busy=0 immediately, no done; with PWM_FADE_PERIOD_SYNC_EN defined, compare changes only on period_start pulses.
